// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, helpers and FSM encoding for the sequential
// round-key generator and any model that needs the same permutations.
package des_pkg;

    // Per-round left-rotate amount; SHIFT[0] is applied when an encrypt pass loads.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // FIPS bit numbers (1 = MSB) of the 64-bit key that feed CD[55..0].
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // CD bit numbers (1 = MSB) that feed round-key bits 47..0.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1[i]];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [55:0] rotate_cd(input logic [55:0] cd, input logic [1:0] n,
                                              input logic right);
        if (right) begin
            return {ror28(cd[55:28], n), ror28(cd[27:0], n)};
        end
        return {rol28(cd[55:28], n), rol28(cd[27:0], n)};
    endfunction

    // 3DES-EDE walks slots K1,K2,K3 forward for encrypt and K3,K2,K1 for decrypt.
    function automatic logic [1:0] pass_slot(input logic tdes, input logic dec,
                                             input logic [1:0] pass);
        if (!tdes) begin
            return 2'd0;
        end
        return dec ? (2'd2 - pass) : pass;
    endfunction

    // The middle 3DES pass runs opposite to the overall direction.
    function automatic logic pass_dec(input logic tdes, input logic dec, input logic [1:0] pass);
        return tdes ? (dec ^ (pass == 2'd1)) : dec;
    endfunction

    // Encrypt starts at C1D1, decrypt at C16D16 which equals C0D0.
    function automatic logic [55:0] load_cd(input logic [63:0] key, input logic dec);
        logic [55:0] p;
        p = pc1(key);
        return dec ? p : rotate_cd(p, 2'd1, 1'b0);
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit CD state into a 48-bit round key.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] rk
);

    always_comb begin
        rk = '0;
        for (int i = 0; i < 48; i++) begin
            rk[47-i] = cd[56-PC2[i]];
        end
    end

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/3DES key scheduler: one PC-2 round key per rk handshake, with
// pass sequencing for 3DES-EDE. Handshakes: a transfer happens on a rising edge
// where valid && ready; valid never drops until its transfer, flush or rst.
module des_key_sched_seq
    import des_pkg::*;
#(
    parameter int NUM_KEYS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    output logic                    key_ready,
    input  logic [64*NUM_KEYS-1:0]  key_in,
    input  logic                    decrypt,
    input  logic                    tdes,
    input  logic                    flush,
    output logic                    rk_valid,
    input  logic                    rk_ready,
    output logic [47:0]             rk_data,
    output logic [3:0]              rk_round,
    output logic [1:0]              rk_pass,
    output logic                    rk_last
);

    state_t                  state_q, state_d;
    logic [64*NUM_KEYS-1:0]  key_q;
    logic                    dec_q, tdes_q;
    logic [55:0]             cd_q;
    logic [3:0]              round_q;
    logic [1:0]              pass_q;

    logic        tdes_eff;
    logic        accept, hs, step_dec;
    logic [1:0]  slot0, pass_nxt, slotn, final_pass;
    logic [55:0] load0, loadn, adv;
    logic [63:0] in_slot [4];
    logic [63:0] st_slot [4];

    assign tdes_eff = (NUM_KEYS == 3) ? tdes : 1'b0;

    // Slots beyond NUM_KEYS alias K1; they are unreachable because tdes is forced off.
    for (genvar g = 0; g < 4; g++) begin : g_slot
        localparam int S = (g < NUM_KEYS) ? g : 0;
        assign in_slot[g] = key_in[64*S +: 64];
        assign st_slot[g] = key_q[64*S +: 64];
    end

    assign slot0      = pass_slot(tdes_eff, decrypt, 2'd0);
    assign load0      = load_cd(in_slot[slot0], pass_dec(tdes_eff, decrypt, 2'd0));
    assign pass_nxt   = pass_q + 2'd1;
    assign slotn      = pass_slot(tdes_q, dec_q, pass_nxt);
    assign loadn      = load_cd(st_slot[slotn], pass_dec(tdes_q, dec_q, pass_nxt));
    assign step_dec   = pass_dec(tdes_q, dec_q, pass_q);
    assign adv        = step_dec ? rotate_cd(cd_q, SHIFT[4'd15 - round_q], 1'b1)
                                 : rotate_cd(cd_q, SHIFT[round_q + 4'd1], 1'b0);
    assign final_pass = tdes_q ? 2'd2 : 2'd0;

    assign accept   = key_ready && key_valid;
    assign hs       = rk_valid && rk_ready;
    assign rk_last  = (state_q == ST_RUN) && (round_q == 4'd15) && (pass_q == final_pass);
    assign rk_round = round_q;
    assign rk_pass  = pass_q;

    des_pc2 u_pc2 (
        .cd (cd_q),
        .rk (rk_data)
    );

    always_comb begin
        state_d   = state_q;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                rk_valid = 1'b1;
                if (rk_ready && rk_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= '0;
            dec_q   <= 1'b0;
            tdes_q  <= 1'b0;
            cd_q    <= '0;
            round_q <= '0;
            pass_q  <= '0;
        end else if (flush) begin
            cd_q    <= '0;
            round_q <= '0;
            pass_q  <= '0;
        end else if (accept) begin
            key_q   <= key_in;
            dec_q   <= decrypt;
            tdes_q  <= tdes_eff;
            cd_q    <= load0;
            round_q <= '0;
            pass_q  <= '0;
        end else if (hs) begin
            if (rk_last) begin
                cd_q    <= '0;
                round_q <= '0;
                pass_q  <= '0;
            end else if (round_q == 4'd15) begin
                // Next pass loads on the wrapping handshake so the stream has no bubble.
                cd_q    <= loadn;
                round_q <= '0;
                pass_q  <= pass_nxt;
            end else begin
                cd_q    <= adv;
                round_q <= round_q + 4'd1;
            end
        end
    end

endmodule
